mem_port_arbiter: RTL

- Shares one byte-wide memory array between the instruction-fetch port and the load/store data port of the processor.
- Arbitrates round-robin between the two ports and sequences each 32-bit access as four byte beats.
- Byte order is big-endian: the lowest address holds bits 31:24.
- Sits between the core's fetch/data paths and the single byte memory array. It enables a multicycle core built around one unified memory.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter onto one byte-wide memory, 4 big-endian beats per word
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata            fetch port (read only)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   load/store port
//   mem_addr/mem_we/mem_wdata, mem_rdata         byte array interface (combinational read)
//   busy                           high while a word access is in flight or being acked
module mem_port_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              last_data_q, last_data_d;   // 1 = data port was granted last
  logic              gnt_data_q, gnt_data_d;     // 1 = current transaction belongs to data port
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [31:0]       cap_word;
  logic              grant_data;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    base_d      = base_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    cap_word    = gnt_data_q ? d_rdata_q : if_rdata_q;
    // Data wins when it is the only requester, or on a tie when fetch went last.
    grant_data  = d_req && (!if_req || !last_data_q);

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          gnt_data_d  = grant_data;
          last_data_d = grant_data;
          base_d      = grant_data ? d_addr : if_addr;
          we_d        = grant_data && d_we;
          wdata_d     = grant_data ? d_wdata : 32'h0;
          beat_d      = 2'd0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!we_q) begin
          // Big-endian: beat 0 fills the most significant byte.
          case (beat_q)
            2'd0:    cap_word[31:24] = mem_rdata;
            2'd1:    cap_word[23:16] = mem_rdata;
            2'd2:    cap_word[15:8]  = mem_rdata;
            default: cap_word[7:0]   = mem_rdata;
          endcase
          if (gnt_data_q) d_rdata_d  = cap_word;
          else            if_rdata_d = cap_word;
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= 2'd0;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      base_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      base_q      <= base_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (state_q == S_BUSY) begin
      mem_addr = base_q + ADDR_W'(beat_q);
      case (beat_q)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  // Gating with reset keeps the byte of the abandoned beat from landing at the reset edge.
  assign mem_we   = (state_q == S_BUSY) && we_q && !reset;
  assign if_ack   = (state_q == S_ACK) && !gnt_data_q;
  assign d_ack    = (state_q == S_ACK) && gnt_data_q;
  assign busy     = (state_q != S_IDLE);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
